gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb: RTL and testbench

Round-robin arbiter and enable sequencer for a shared tri-state net driven by N `invz` tri-state inverter cells. It accepts per-driver requests and produces one-hot `EN` lines for the `invz` cells. It enforces break-before-make: no cycle ever has two enables high, and at least `TA` all-off cycles separate consecutive owners. It also limits ownership time so every requester is served.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb_if.sv | 14 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb.sv | 134 +++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb_if.sv
// Bus bundle between the invz enable arbiter and the requesting drivers.
// The master side drives REQ; the slave side (the arbiter) drives the enables and status.
interface gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb_if #(
    parameter int N = 4
);
    logic [N-1:0]         REQ;
    logic [N-1:0]         EN;
    logic [$clog2(N)-1:0] OWNER;
    logic                 BUSY;
    logic                 TURN;

    modport master (output REQ, input EN, OWNER, BUSY, TURN);
    modport slave  (input REQ, output EN, OWNER, BUSY, TURN);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb.sv
// Round-robin arbiter for a shared tri-state net: one-hot EN lines with
// break-before-make turnaround and a bounded hold time under contention.
module gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb #(
    parameter int N        = 4,
    parameter int TA       = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb_if.slave bus
);
    localparam int OW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    en_q, en_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [7:0]      hc_q, hc_d;
    logic [3:0]      tc_q, tc_d;
    logic            busy_q, busy_d;
    logic            turn_q, turn_d;

    logic [OW-1:0]   winner;
    logic [OW-1:0]   owner_next_idx;
    logic            any_req;
    logic            others_req;

    // First requester at or after ptr, scanning circularly; the lowest offset wins.
    function automatic logic [OW-1:0] pick_winner(input logic [N-1:0] req, input logic [OW-1:0] ptr);
        logic [OW:0] idx;
        pick_winner = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (OW+1)'(k);
            if (idx >= (OW+1)'(N)) begin
                idx = idx - (OW+1)'(N);
            end
            if (req[idx[OW-1:0]]) begin
                pick_winner = idx[OW-1:0];
            end
        end
    endfunction

    assign winner         = pick_winner(bus.REQ, ptr_q);
    assign any_req        = |bus.REQ;
    assign others_req     = |(bus.REQ & ~en_q);
    assign owner_next_idx = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hc_d    = hc_q;
        tc_d    = tc_q;
        turn_d  = turn_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                    en_d    = {{(N-1){1'b0}}, 1'b1} << winner;
                    owner_d = winner;
                    hc_d    = 8'd1;
                end
            end
            ST_GRANT: begin
                if (!bus.REQ[owner_q] || (hc_q == 8'(HOLD_MAX) && others_req)) begin
                    state_d = ST_TURN;
                    en_d    = '0;
                    turn_d  = 1'b1;
                    tc_d    = 4'd1;
                    ptr_d   = owner_next_idx;
                end else if (hc_q != 8'(HOLD_MAX)) begin
                    hc_d = hc_q + 8'd1;
                end
            end
            ST_TURN: begin
                if (tc_q < 4'(TA)) begin
                    tc_d = tc_q + 4'd1;
                end else if (any_req) begin
                    // ptr already points past the previous owner, so it re-requests last.
                    state_d = ST_GRANT;
                    en_d    = {{(N-1){1'b0}}, 1'b1} << winner;
                    owner_d = winner;
                    hc_d    = 8'd1;
                    turn_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    turn_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
                turn_d  = 1'b0;
            end
        endcase

        busy_d = |en_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hc_q    <= '0;
            tc_q    <= '0;
            busy_q  <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hc_q    <= hc_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            turn_q  <= turn_d;
        end
    end

    assign bus.EN    = en_q;
    assign bus.OWNER = owner_q;
    assign bus.BUSY  = busy_q;
    assign bus.TURN  = turn_q;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb.sv
// Bench for the invz bus arbiter: two instances (TA=1 and TA=3) share one
// request stream and are compared every cycle against a behavioural model.
module tb_gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb;
    localparam int N    = 4;
    localparam int HOLD = 4;

    logic         CLK = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    bit           chk_en = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb_if #(.N(N)) if_a ();
    gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb_if #(.N(N)) if_b ();
    assign if_a.REQ = req;
    assign if_b.REQ = req;

    gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb #(.N(N), .TA(1), .HOLD_MAX(HOLD)) dut_a (
        .CLK(CLK), .RST(rst), .bus(if_a)
    );
    gf180mcu_fd_sc_mcu7t5v0__invz_bus_arb #(.N(N), .TA(3), .HOLD_MAX(HOLD)) dut_b (
        .CLK(CLK), .RST(rst), .bus(if_b)
    );

    // cur = enabled driver or -1; gap = turnaround cycles elapsed (0 = none).
    typedef struct {
        int cur;
        int owner;
        int ptr;
        int held;
        int gap;
    } mstate_t;

    mstate_t ma = '{cur: -1, owner: 0, ptr: 0, held: 0, gap: 0};
    mstate_t mb = '{cur: -1, owner: 0, ptr: 0, held: 0, gap: 0};

    function automatic mstate_t step(mstate_t s, logic [N-1:0] r, logic rs, int ta);
        mstate_t n = s;
        logic [N-1:0] one = 1;
        bit others;
        if (rs) begin
            n.cur = -1; n.owner = 0; n.ptr = 0; n.held = 0; n.gap = 0;
            return n;
        end
        if (s.cur >= 0) begin
            others = (r & ~(one << s.cur)) != 0;
            if (!r[s.cur] || (s.held >= HOLD && others)) begin
                n.cur = -1;
                n.gap = 1;
                n.ptr = (s.owner + 1) % N;
            end else begin
                n.held = (s.held + 1 > HOLD) ? HOLD : s.held + 1;
            end
        end else if (s.gap > 0 && s.gap < ta) begin
            n.gap = s.gap + 1;
        end else begin
            n.gap = 0;
            for (int k = 0; k < N; k++) begin
                if (r[(s.ptr + k) % N] && n.cur < 0) begin
                    n.cur   = (s.ptr + k) % N;
                    n.owner = n.cur;
                    n.held  = 1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [N-1:0] en_of(mstate_t s);
        logic [N-1:0] one = 1;
        return (s.cur >= 0) ? (one << s.cur) : '0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        ma <= step(ma, req, rst, 1);
        mb <= step(mb, req, rst, 3);
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("A.EN",    32'(if_a.EN),    32'(en_of(ma)));
            chk("A.OWNER", 32'(if_a.OWNER), 32'(ma.owner));
            chk("A.BUSY",  32'(if_a.BUSY),  32'(ma.cur >= 0));
            chk("A.TURN",  32'(if_a.TURN),  32'(ma.gap > 0));
            chk("B.EN",    32'(if_b.EN),    32'(en_of(mb)));
            chk("B.OWNER", 32'(if_b.OWNER), 32'(mb.owner));
            chk("B.BUSY",  32'(if_b.BUSY),  32'(mb.cur >= 0));
            chk("B.TURN",  32'(if_b.TURN),  32'(mb.gap > 0));
        end
    end

    a_onehot: assert property (@(posedge CLK) disable iff (!chk_en)
        $onehot0(if_a.EN) && (if_a.BUSY == |if_a.EN) && $onehot0(if_b.EN) && (if_b.BUSY == |if_b.EN));

    task automatic tick(int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        tick(2);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("pin reset EN", 32'(en_of(ma)), 32'h0);
        chk("pin reset OWNER", 32'(ma.owner), 32'h0);
        chk("pin reset TURN", 32'(ma.gap > 0), 32'h0);

        $display("txn basic grant/release");
        req = 4'b0001; tick(1);
        chk("pin grant EN", 32'(en_of(ma)), 32'h1);
        chk("pin grant BUSY", 32'(ma.cur >= 0), 32'h1);
        tick(3);
        chk("pin hold EN", 32'(en_of(ma)), 32'h1);
        req = 4'b0000; tick(1);
        chk("pin release EN", 32'(en_of(ma)), 32'h0);
        chk("pin release TURN", 32'(ma.gap > 0), 32'h1);
        tick(1);
        chk("pin idle TURN", 32'(ma.gap > 0), 32'h0);

        $display("txn handover");
        rst_pulse();
        req = 4'b0101; tick(1);
        chk("pin ho first EN", 32'(en_of(ma)), 32'h1);
        req = 4'b0100; tick(1);
        chk("pin ho gap A", 32'(en_of(ma)), 32'h0);
        chk("pin ho gap B", 32'(en_of(mb)), 32'h0);
        tick(1);
        chk("pin ho new EN A", 32'(en_of(ma)), 32'h4);
        chk("pin ho new OWNER A", 32'(ma.owner), 32'h2);
        chk("pin ho gap2 B", 32'(en_of(mb)), 32'h0);
        tick(1);
        chk("pin ho gap3 B", 32'(en_of(mb)), 32'h0);
        tick(1);
        chk("pin ho new EN B", 32'(en_of(mb)), 32'h4);

        $display("txn full rotation");
        rst_pulse();
        req = 4'b1111; tick(1);
        for (int c = 0; c < 20; c++) begin
            chk("pin rotation EN", 32'(en_of(ma)), ((c % 5) < 4) ? (32'h1 << (c / 5)) : 32'h0);
            tick(1);
        end

        $display("txn reset mid-grant");
        rst_pulse();
        req = 4'b0100; tick(1);
        chk("pin mid EN", 32'(en_of(ma)), 32'h4);
        rst = 1'b1; tick(1);
        chk("pin midrst EN", 32'(en_of(ma)), 32'h0);
        chk("pin midrst OWNER", 32'(ma.owner), 32'h0);
        rst = 1'b0; req = 4'b1111; tick(1);
        chk("pin after rst EN", 32'(en_of(ma)), 32'h1);

        $display("txn sole requester");
        rst_pulse();
        req = 4'b0010;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            chk("pin sole EN", 32'(en_of(ma)), 32'h2);
        end

        $display("txn random stream");
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 149) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
